// File: rtl/maze_path_player_if.sv
// Move-stream handshake between the maze solver (master) and the path player (slave).
// Carries one 2-bit direction code per transfer plus an end-of-path marker.
interface maze_path_player_if;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       move_last;
   logic       move_ready;

   modport master (output move_valid, output move_dir, output move_last, input move_ready);
   modport slave  (input move_valid, input move_dir, input move_last, output move_ready);
endinterface

// File: rtl/maze_path_player.sv
// Stores a solved maze path and replays it from (0,0), one step every STEP_DIV cycles.
// Define MAZE_PLAYER_BOUNDS_EN to clamp off-grid steps and flag them on bad_move.
module maze_path_player #(
   parameter int N        = 4,
   parameter int DEPTH    = 256,
   parameter int STEP_DIV = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   maze_path_player_if.slave            mv,
   input  logic                         run,
   output logic [N-1:0]                 x,
   output logic [N-1:0]                 y,
   output logic                         playing,
   output logic                         done,
   output logic [$clog2(DEPTH+1)-1:0]   step_count,
   output logic [$clog2(DEPTH+1)-1:0]   path_len,
   output logic                         truncated,
   output logic                         bad_move
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

   typedef enum logic [1:0] {IDLE, READY, PLAY, DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] path_len_q, path_len_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] step_count_q, step_count_d;
   logic [DW-1:0] div_q, div_d;
   logic [N-1:0]  x_q, x_d, y_q, y_d;
   logic          playing_q, playing_d;
   logic          done_q, done_d;
   logic          truncated_q, truncated_d;
   logic          bad_move_q, bad_move_d;

   logic [1:0]    path_mem [DEPTH];
   logic          move_ready;
   logic          mem_we;
   logic [1:0]    cur_dir;
   logic [N-1:0]  step_x, step_y;
`ifdef MAZE_PLAYER_BOUNDS_EN
   logic          step_bad;
`endif

   assign move_ready    = (state_q == IDLE) && (path_len_q < DEPTH_C);
   assign mv.move_ready = move_ready;
   assign mem_we        = move_ready && mv.move_valid;
   assign cur_dir       = path_mem[rd_ptr_q[AW-1:0]];

   // Path storage has no reset; path_len alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (mem_we) path_mem[path_len_q[AW-1:0]] <= mv.move_dir;
   end

   always_comb begin
      step_x = x_q;
      step_y = y_q;
`ifdef MAZE_PLAYER_BOUNDS_EN
      step_bad = 1'b0;
      case (cur_dir)
         2'b00:   if (y_q == '0) step_bad = 1'b1; else step_y = y_q - 1'b1;
         2'b01:   if (x_q == '1) step_bad = 1'b1; else step_x = x_q + 1'b1;
         2'b10:   if (y_q == '1) step_bad = 1'b1; else step_y = y_q + 1'b1;
         default: if (x_q == '0) step_bad = 1'b1; else step_x = x_q - 1'b1;
      endcase
`else
      case (cur_dir)
         2'b00:   step_y = y_q - 1'b1;
         2'b01:   step_x = x_q + 1'b1;
         2'b10:   step_y = y_q + 1'b1;
         default: step_x = x_q - 1'b1;
      endcase
`endif
   end

   always_comb begin
      state_d      = state_q;
      path_len_d   = path_len_q;
      rd_ptr_d     = rd_ptr_q;
      step_count_d = step_count_q;
      div_d        = div_q;
      x_d          = x_q;
      y_d          = y_q;
      truncated_d  = truncated_q;
      bad_move_d   = bad_move_q;

      case (state_q)
         IDLE: begin
            if (mem_we) begin
               path_len_d = path_len_q + 1'b1;
               if (mv.move_last) begin
                  state_d = READY;
               end else if (path_len_d == DEPTH_C) begin
                  truncated_d = 1'b1;
                  state_d     = READY;
               end
            end
         end
         READY, DONE: begin
            if (run) begin
               state_d      = PLAY;
               x_d          = '0;
               y_d          = '0;
               rd_ptr_d     = '0;
               step_count_d = '0;
               div_d        = '0;
            end
         end
         PLAY: begin
            // With run low nothing moves, so every paused cycle shifts later steps by one.
            if (run) begin
               if (div_q == DIV_LAST) begin
                  div_d        = '0;
                  x_d          = step_x;
                  y_d          = step_y;
                  rd_ptr_d     = rd_ptr_q + 1'b1;
                  step_count_d = step_count_q + 1'b1;
`ifdef MAZE_PLAYER_BOUNDS_EN
                  if (step_bad) bad_move_d = 1'b1;
`endif
                  if (rd_ptr_q == path_len_q - 1'b1) state_d = DONE;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (clr) begin
         state_d      = IDLE;
         path_len_d   = '0;
         rd_ptr_d     = '0;
         step_count_d = '0;
         div_d        = '0;
         x_d          = '0;
         y_d          = '0;
         truncated_d  = 1'b0;
         bad_move_d   = 1'b0;
      end

      playing_d = (state_d == PLAY);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         path_len_q   <= '0;
         rd_ptr_q     <= '0;
         step_count_q <= '0;
         div_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         playing_q    <= 1'b0;
         done_q       <= 1'b0;
         truncated_q  <= 1'b0;
         bad_move_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         path_len_q   <= path_len_d;
         rd_ptr_q     <= rd_ptr_d;
         step_count_q <= step_count_d;
         div_q        <= div_d;
         x_q          <= x_d;
         y_q          <= y_d;
         playing_q    <= playing_d;
         done_q       <= done_d;
         truncated_q  <= truncated_d;
         bad_move_q   <= bad_move_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign playing    = playing_q;
   assign done       = done_q;
   assign step_count = step_count_q;
   assign path_len   = path_len_q;
   assign truncated  = truncated_q;
   assign bad_move   = bad_move_q;

endmodule

// File: tb/tb_maze_path_player.sv
// Directed bench for maze_path_player: one instance at STEP_DIV=1 and one at STEP_DIV=3.
// Expected positions are worked out by hand from the move codes.
module tb_maze_path_player;

   localparam logic [1:0] MU = 2'b00;
   localparam logic [1:0] MR = 2'b01;
   localparam logic [1:0] MD = 2'b10;
   localparam logic [1:0] ML = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr1, clr3, run1, run3;
   logic [3:0] x1, y1, x3, y3;
   logic       playing1, done1, tr1, bm1;
   logic       playing3, done3, tr3, bm3;
   logic [8:0] sc1, pl1, sc3, pl3;

   int compared   = 0;
   int mismatched = 0;

   maze_path_player_if if1 ();
   maze_path_player_if if3 ();

   maze_path_player #(.N(4), .DEPTH(256), .STEP_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .clr(clr1), .mv(if1.slave), .run(run1),
      .x(x1), .y(y1), .playing(playing1), .done(done1),
      .step_count(sc1), .path_len(pl1), .truncated(tr1), .bad_move(bm1));

   maze_path_player #(.N(4), .DEPTH(256), .STEP_DIV(3)) u_dut3 (
      .clk(clk), .rst(rst), .clr(clr3), .mv(if3.slave), .run(run3),
      .x(x3), .y(y3), .playing(playing3), .done(done3),
      .step_count(sc3), .path_len(pl3), .truncated(tr3), .bad_move(bm3));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Presents one move and clocks it in; valid stays high so consecutive calls stream back to back.
   task automatic applyStimulus(input bit sel3, input logic [1:0] d, input logic l);
      if (sel3) begin
         if3.move_valid = 1'b1; if3.move_dir = d; if3.move_last = l;
      end else begin
         if1.move_valid = 1'b1; if1.move_dir = d; if1.move_last = l;
      end
      tick();
   endtask

   task automatic pulseClr1();
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
   endtask

   initial begin
      int ex [5];
      int ey [5];
      int px [11];
      ex = '{1, 2, 2, 2, 1};
      ey = '{0, 0, 1, 2, 2};
      px = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

      rst = 1'b1; clr1 = 1'b0; clr3 = 1'b0; run1 = 1'b0; run3 = 1'b0;
      if1.move_valid = 1'b0; if1.move_dir = 2'b00; if1.move_last = 1'b0;
      if3.move_valid = 1'b0; if3.move_dir = 2'b00; if3.move_last = 1'b0;
      #2;
      checkOutput("rst_x", x1, 0);
      checkOutput("rst_y", y1, 0);
      checkOutput("rst_playing", playing1, 0);
      checkOutput("rst_done", done1, 0);
      checkOutput("rst_step_count", sc1, 0);
      checkOutput("rst_path_len", pl1, 0);
      checkOutput("rst_truncated", tr1, 0);
      checkOutput("rst_bad_move", bm1, 0);
      checkOutput("rst_move_ready", if1.move_ready, 1);
      checkOutput("rst_move_ready3", if3.move_ready, 1);
      tick();
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] basic replay");
      applyStimulus(0, MR, 0);
      applyStimulus(0, MR, 0);
      applyStimulus(0, MD, 0);
      applyStimulus(0, MD, 0);
      applyStimulus(0, ML, 1);
      if1.move_valid = 1'b0;
      checkOutput("load_path_len", pl1, 5);
      checkOutput("ready_move_ready", if1.move_ready, 0);
      checkOutput("ready_playing", playing1, 0);
      run1 = 1'b1;
      tick();
      checkOutput("play_entry_playing", playing1, 1);
      checkOutput("play_entry_x", x1, 0);
      checkOutput("play_entry_y", y1, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 4) run1 = 1'b0;
         checkOutput($sformatf("step%0d_x", i), x1, ex[i]);
         checkOutput($sformatf("step%0d_y", i), y1, ey[i]);
         if (i == 3) checkOutput("step3_done", done1, 0);
      end
      checkOutput("basic_done", done1, 1);
      checkOutput("basic_playing", playing1, 0);
      checkOutput("basic_step_count", sc1, 5);
      checkOutput("basic_path_len", pl1, 5);
      tick();
      checkOutput("done_hold_x", x1, 1);
      checkOutput("done_hold_y", y1, 2);
      checkOutput("done_hold_done", done1, 1);

      $display("[TB] replay and clear");
      run1 = 1'b1;
      tick();
      checkOutput("replay_x", x1, 0);
      checkOutput("replay_y", y1, 0);
      checkOutput("replay_step_count", sc1, 0);
      checkOutput("replay_done", done1, 0);
      checkOutput("replay_playing", playing1, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 4) run1 = 1'b0;
         checkOutput($sformatf("replay%0d_x", i), x1, ex[i]);
         checkOutput($sformatf("replay%0d_y", i), y1, ey[i]);
      end
      checkOutput("replay_done_end", done1, 1);
      checkOutput("replay_step_count_end", sc1, 5);
      pulseClr1();
      checkOutput("clr_path_len", pl1, 0);
      checkOutput("clr_move_ready", if1.move_ready, 1);
      checkOutput("clr_done", done1, 0);
      checkOutput("clr_x", x1, 0);
      checkOutput("clr_y", y1, 0);

      $display("[TB] reset mid-replay");
      applyStimulus(0, MR, 0);
      applyStimulus(0, MR, 0);
      applyStimulus(0, MD, 0);
      applyStimulus(0, MD, 0);
      applyStimulus(0, ML, 1);
      if1.move_valid = 1'b0;
      run1 = 1'b1;
      tick();
      tick();
      checkOutput("mid_step1_x", x1, 1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_x", x1, 0);
      checkOutput("async_rst_playing", playing1, 0);
      checkOutput("async_rst_path_len", pl1, 0);
      checkOutput("async_rst_step_count", sc1, 0);
      run1 = 1'b0;
      #1;
      rst = 1'b0;
      tick();
      checkOutput("post_rst_move_ready", if1.move_ready, 1);
      checkOutput("post_rst_path_len", pl1, 0);
      checkOutput("post_rst_playing", playing1, 0);

      $display("[TB] backpressure");
      if1.move_valid = 1'b1;
      if1.move_last  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if1.move_dir = 2'(i);
         if (i == 255) checkOutput("bp_ready_before_last", if1.move_ready, 1);
         tick();
      end
      checkOutput("bp_move_ready", if1.move_ready, 0);
      checkOutput("bp_truncated", tr1, 1);
      checkOutput("bp_path_len", pl1, 256);
      tick();
      checkOutput("bp_257_path_len", pl1, 256);
      checkOutput("bp_257_ready", if1.move_ready, 0);
      if1.move_valid = 1'b0;
      run1 = 1'b1;
      tick();
      checkOutput("bp_ready_state_run", playing1, 1);
      run1 = 1'b0;
      pulseClr1();
      checkOutput("bp_clr_truncated", tr1, 0);

      $display("[TB] bounds");
      applyStimulus(0, MU, 0);
      applyStimulus(0, ML, 1);
      if1.move_valid = 1'b0;
      run1 = 1'b1;
      tick();
      tick();
`ifdef MAZE_PLAYER_BOUNDS_EN
      checkOutput("bounds_up_y", y1, 0);
      checkOutput("bounds_up_bad", bm1, 1);
`else
      checkOutput("wrap_up_y", y1, 15);
      checkOutput("wrap_up_bad", bm1, 0);
`endif
      tick();
      run1 = 1'b0;
`ifdef MAZE_PLAYER_BOUNDS_EN
      checkOutput("bounds_left_x", x1, 0);
      checkOutput("bounds_left_bad", bm1, 1);
`else
      checkOutput("wrap_left_x", x1, 15);
      checkOutput("wrap_left_bad", bm1, 0);
`endif
      checkOutput("bounds_done", done1, 1);
      checkOutput("bounds_step_count", sc1, 2);
      pulseClr1();
      checkOutput("bounds_clr_bad", bm1, 0);

      $display("[TB] pause and divider");
      applyStimulus(1, MR, 0);
      applyStimulus(1, MR, 0);
      applyStimulus(1, MR, 1);
      if3.move_valid = 1'b0;
      checkOutput("div_path_len", pl3, 3);
      run3 = 1'b1;
      tick();
      checkOutput("div_entry_playing", playing3, 1);
      checkOutput("div_entry_x", x3, 0);
      for (int i = 0; i < 11; i++) begin
         tick();
         checkOutput($sformatf("div_k%0d_x", i + 1), x3, px[i]);
         checkOutput($sformatf("div_k%0d_done", i + 1), done3, (i == 10) ? 1 : 0);
         if (i == 2) run3 = 1'b0;
         if (i == 4) run3 = 1'b1;
         if (i == 10) run3 = 1'b0;
      end
      checkOutput("div_playing_end", playing3, 0);
      checkOutput("div_step_count", sc3, 3);
      checkOutput("div_y", y3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/maze_path_player.md
# maze_path_player

Consumer end of the maze solver's move-output stream. Accepts the solver's solved path as a sequence of 2-bit direction codes over a valid/ready handshake and stores it in an internal path buffer. On `run`, it replays the path one step at a time from the start cell (0,0), driving the rat's current (x,y) position for display or checking. Replay is non-destructive, so the path can be replayed until cleared.

## Interface
- `N`, 4: coordinate width; maze is 2^N x 2^N.
- `DEPTH`, 256: maximum stored path length, in moves.
- `STEP_DIV`, 1: clock cycles per replay step; must be at least 1.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `clr` input, 1 bit: synchronous clear; same effect as reset.
- `move_valid` input, 1 bit: `move_dir`/`move_last` valid.
- `move_dir` input, 2 bits: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- `move_last` input, 1 bit: final move of the path.
- `move_ready` output, 1 bit: buffer accepting moves.
- `run` input, 1 bit: start or continue replay; level-sensitive.
- `x`, `y` outputs, N bits each: current rat position.
- `playing` output, 1 bit: state is PLAY.
- `done` output, 1 bit: replay finished.
- `step_count` output, $clog2(DEPTH+1) bits: number of moves applied in the current replay.
- `path_len` output, $clog2(DEPTH+1) bits: number of stored moves.
- `truncated` output, 1 bit: sticky; buffer filled without `move_last`.
- `bad_move` output, 1 bit: sticky; a step tried to leave the grid.

## Operation
- **States:** IDLE (loading), READY, PLAY, DONE.
- **Reset / `clr`:**
  - State goes to IDLE.
  - All outputs go to 0, except `move_ready`, which is 1.
  - `path_len`, read pointer and divider are cleared.
- **IDLE (loading):**
  - `move_ready` = (`path_len` < DEPTH).
  - A transfer occurs at a rising edge where `move_valid` and `move_ready` are both 1. The move is written at index `path_len`, then `path_len` increments.
  - An accepted move with `move_last`=1 moves the state to READY.
  - If `path_len` reaches DEPTH without `move_last`, set `truncated` and go to READY.
- **READY:**
  - `move_ready`=0.
  - Rising edge with `run`=1: go to PLAY; set x=y=0, read pointer=0, `step_count`=0, divider=0.
- **PLAY:**
  - The divider counts only while `run`=1. While `run`=0, replay pauses: all registers hold and `playing` stays 1.
  - When `run`=1 and divider = STEP_DIV-1, one step is taken:
    - Apply `move[rd_ptr]` to x/y.
    - Increment `rd_ptr` and `step_count`.
    - Reset the divider to 0.
  - If the step applied index `path_len`-1, go to DONE on the same edge.
- **DONE:**
  - `done`=1 and x/y hold the final cell.
  - Rising edge with `run`=1 replays: go to PLAY with x=y=0 and `step_count`=0. Stored moves and `path_len` are kept; `done` drops.
- `move_valid` is ignored outside IDLE. A new path requires `clr` first.
- Arithmetic is modulo 2^N unless bounds checking is enabled (see Configuration).
- `clr` takes priority over all other inputs in any state.
- `rst` asserted mid-replay aborts immediately and asynchronously.

## Timing
- All outputs are registered; there are no combinational input-to-output paths except `move_ready`, which is decoded from state and `path_len` only.
- **Handshake:** the transfer completes at the edge where `move_valid` & `move_ready`. The source holds `move_dir`/`move_last` until that edge. Throughput is one move per cycle.
- **Replay start:** `run` sampled in READY at edge k gives `playing`=1 and x=y=0 after edge k.
- **First step:** with `run` held, the first move is visible after edge k+STEP_DIV; each following step comes STEP_DIV cycles later.
- **Total replay:** for path length L with `run` held, `done`=1 after edge k+L·STEP_DIV, and `playing` falls on that same edge.
- **Pause:** each cycle with `run`=0 in PLAY delays all subsequent steps by exactly one cycle.

## Configuration
- **`MAZE_PLAYER_BOUNDS_EN` defined:**
  - Any step that would move x or y below 0 or above 2^N-1 leaves that coordinate unchanged.
  - It sets `bad_move` (sticky until `rst`/`clr`).
  - `step_count` still increments.
- **`MAZE_PLAYER_BOUNDS_EN` undefined:**
  - Coordinates wrap modulo 2^N.
  - `bad_move` is tied to 0.

## Test plan
- **Basic replay:** load R,R,D,D,L (last on L), then `run`=1 with STEP_DIV=1. Required: x/y sequence (1,0),(2,0),(2,1),(2,2),(1,2); `done`=1 five cycles after PLAY entry; `path_len`=5; `step_count`=5.
- **Backpressure:** load 256 moves with no `move_last`. Required: `move_ready`=0 after the 256th transfer, `truncated`=1, state READY, and a 257th `move_valid` is not accepted.
- **Pause and divider:** STEP_DIV=3, path R,R,R; drop `run` for 2 cycles after the first step. Required: x=1 held 5 cycles total; `done` at PLAY entry + 11 cycles; final x=3.
- **Bounds:** path U,L from (0,0). With `MAZE_PLAYER_BOUNDS_EN`: x=y=0 and `bad_move`=1. Without it: y=15, x=15, `bad_move`=0.
- **Replay and clear:** after DONE, pulse `run`. Required: x=y=0, `step_count`=0, identical sequence again. Then `clr`: state IDLE, `path_len`=0, `move_ready`=1.
- **Reset mid-replay:** assert `rst` during step 2 of 5. Required: all outputs 0 immediately, `move_ready`=1 after release, stored path discarded.
